gray_monitor: RTL

- Downstream checker for the 3-bit Gray-code counter stage. It consumes the counter's Gray output and its sticky overflow flag.
- Each enabled cycle: converts the Gray code to binary, checks that the sequence is legal (hold or +1 mod 2^WIDTH), counts wrap-arounds, and cross-checks the overflow flag against the detected wraps.
- Sits between the counter and display/debug logic; raises a sticky Error when the upstream misbehaves.

---
 rtl/gray_monitor.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/gray_monitor.sv
// gray_monitor: converts an upstream Gray counter to binary, checks step legality, counts wraps
// and cross-checks the sticky overflow flag. Optional build macro: GRAY_MON_ERRCNT_EN.
module gray_monitor #(
    parameter int WIDTH  = 3,
    parameter int WRAP_W = 8
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              En,
    input  logic              Clear,
    input  logic [WIDTH-1:0]  GrayIn,
    input  logic              OverflowIn,
    output logic [WIDTH-1:0]  BinOut,
    output logic              Valid,
    output logic [WRAP_W-1:0] WrapCount,
    output logic              Error
`ifdef GRAY_MON_ERRCNT_EN
    ,
    output logic [7:0]        ErrCount
`endif
);

    typedef enum logic [1:0] {IDLE, TRACK, ERROR} state_t;

    state_t             state, state_nxt;
    logic               ovf_prev;
    logic [WIDTH-1:0]   bin_p0, bin_inc;
    logic               seq_ok, is_wrap, ovf_ok, violation;
    logic [WIDTH-1:0]   bin_nxt;
    logic               ovf_nxt, valid_nxt, err_nxt;
    logic [WRAP_W-1:0]  wrap_nxt;
`ifdef GRAY_MON_ERRCNT_EN
    logic [7:0]         ecnt_nxt;
`endif

    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b = '0;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [WRAP_W-1:0] sat_inc_wrap(input logic [WRAP_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

`ifdef GRAY_MON_ERRCNT_EN
    function automatic logic [7:0] sat_inc_err(input logic [7:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction
`endif

    // Sample stage: combinational decode and legality checks against the last accepted value
    assign bin_p0  = gray2bin(GrayIn);
    assign bin_inc = BinOut + 1'b1;
    assign seq_ok  = (bin_p0 == BinOut) || (bin_p0 == bin_inc);
    assign is_wrap = (&BinOut) && (bin_p0 == '0);
    // A wrap must carry the flag; otherwise the sticky flag may neither rise nor fall
    assign ovf_ok    = is_wrap ? OverflowIn : (ovf_prev == OverflowIn);
    assign violation = !seq_ok || !ovf_ok;

    always_comb begin
        state_nxt = state;
        bin_nxt   = BinOut;
        ovf_nxt   = ovf_prev;
        valid_nxt = Valid;
        wrap_nxt  = WrapCount;
`ifdef GRAY_MON_ERRCNT_EN
        err_nxt   = 1'b0;
        ecnt_nxt  = ErrCount;
`else
        err_nxt   = Error;
`endif
        if (Clear) begin
            state_nxt = IDLE;
            err_nxt   = 1'b0;
            valid_nxt = 1'b0;
`ifdef GRAY_MON_ERRCNT_EN
            ecnt_nxt  = '0;
`endif
        end else if (En) begin
            case (state)
                IDLE: begin
                    bin_nxt   = bin_p0;
                    ovf_nxt   = OverflowIn;
                    valid_nxt = 1'b1;
                    state_nxt = TRACK;
                end
                TRACK: begin
                    if (violation) begin
`ifdef GRAY_MON_ERRCNT_EN
                        // Resync on the offending sample instead of locking up
                        err_nxt  = 1'b1;
                        ecnt_nxt = sat_inc_err(ErrCount);
                        bin_nxt  = bin_p0;
                        ovf_nxt  = OverflowIn;
                        if (is_wrap) wrap_nxt = sat_inc_wrap(WrapCount);
`else
                        err_nxt   = 1'b1;
                        valid_nxt = 1'b0;
                        state_nxt = ERROR;
`endif
                    end else begin
                        bin_nxt = bin_p0;
                        ovf_nxt = OverflowIn;
                        if (is_wrap) wrap_nxt = sat_inc_wrap(WrapCount);
                    end
                end
                default: ;
            endcase
        end
    end

    // Register stage: all outputs update together, one cycle after the sample
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= IDLE;
            BinOut    <= '0;
            ovf_prev  <= 1'b0;
            Valid     <= 1'b0;
            WrapCount <= '0;
            Error     <= 1'b0;
`ifdef GRAY_MON_ERRCNT_EN
            ErrCount  <= '0;
`endif
        end else begin
            state     <= state_nxt;
            BinOut    <= bin_nxt;
            ovf_prev  <= ovf_nxt;
            Valid     <= valid_nxt;
            WrapCount <= wrap_nxt;
            Error     <= err_nxt;
`ifdef GRAY_MON_ERRCNT_EN
            ErrCount  <= ecnt_nxt;
`endif
        end
    end

endmodule
